vga_lock_code_entry: RTL and testbench
======================================

Name: vga_lock_code_entry

Overview:
- Button-driven passcode entry and lock controller for the VGA board lock.
- Sits directly upstream of the binary-to-hex digit converter. It produces the 4-bit nibble being edited and the packed entered code; the converter and VGA text stages consume these for display.
- Debounces four push-buttons, lets the user edit one hex digit at a time, and compares the completed code against a stored passcode.
- Handles failed-attempt lockout and reprogramming of the passcode while unlocked.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable-high cycles needed to accept a button press.
- MAX_ATTEMPTS, 3: consecutive failed checks that trigger lockout (1..7).
- LOCKOUT_CYCLES, 50000000: duration of the lockout state in clk cycles.
- DEFAULT_CODE, 16'h1234: passcode loaded at reset.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- btn_up, input, 1: raw button; increments the current digit.
- btn_down, input, 1: raw button; decrements the current digit.
- btn_enter, input, 1: raw button; commits the current digit.
- btn_clear, input, 1: raw button; aborts entry, or relocks when unlocked.
- set_mode, input, 1: level switch; selects passcode programming while unlocked.
- digit_nibble, output, 4: value of the digit being edited; feeds the hex converter.
- digit_index, output, 2: position being edited (0 = most significant).
- entered_code, output, 16: digits committed so far; digit k is at [15-4k:12-4k].
- unlocked, output, 1: high in UNLOCKED and PROGRAM.
- locked_out, output, 1: high in LOCKOUT.
- attempt_fail, output, 1: one-cycle pulse on each failed check.
- fsm_state, output, 3: current state encoding, for display and debug.

Behaviour:
- Reset (rst_n low at a clock edge):
  - digit_nibble = 0, digit_index = 0, entered_code = 0.
  - unlocked = 0, locked_out = 0, attempt_fail = 0.
  - stored code = DEFAULT_CODE, attempt counter = 0, state = ENTRY.
  - Debounce counters and edge registers cleared.
  - Applies mid-operation too, including during LOCKOUT and PROGRAM.
- Debounce (per button):
  - Raw input passes through a 2-flop synchronizer.
  - The counter increments while the synced input is high and clears when it is low.
  - The debounced level goes high when the count reaches DEBOUNCE_CYCLES and goes low on the first low sample.
  - A one-cycle press pulse fires on the rising edge of the debounced level. Holding a button produces exactly one pulse.
- Pulse priority within one cycle: clear > enter > up > down. Only the highest-priority pulse acts.
- States: 0 ENTRY, 1 CHECK, 2 UNLOCKED, 3 PROGRAM, 4 LOCKOUT.
- ENTRY:
  - up: digit_nibble+1, wrapping F->0. down: digit_nibble-1, wrapping 0->F.
  - enter: write digit_nibble into entered_code slot digit_index, then set digit_nibble = 0.
    - If digit_index == 3, go to CHECK; otherwise digit_index+1.
  - clear: entered_code = 0, digit_index = 0, digit_nibble = 0.
- CHECK: one cycle; all buttons ignored.
  - Match:
    - Go to UNLOCKED and clear the attempt counter.
    - Clear the entry registers.
  - Mismatch:
    - Pulse attempt_fail, increment the attempt counter and clear the entry registers.
    - If the new count == MAX_ATTEMPTS, go to LOCKOUT; otherwise go to ENTRY.
- UNLOCKED:
  - clear: go to ENTRY (relock).
  - enter with set_mode = 1: go to PROGRAM with entry registers cleared.
  - All other presses ignored.
- PROGRAM:
  - Editing is identical to ENTRY.
  - On commit of digit 3, the stored code is loaded with the full 16-bit value (including the digit just committed). Entry registers are cleared and the state returns to UNLOCKED.
  - clear: abort with no change to the stored code, return to UNLOCKED.
  - set_mode dropping mid-program has no effect.
- LOCKOUT:
  - Timer loads LOCKOUT_CYCLES-1 on entry and decrements each cycle; all presses are ignored.
  - At 0: attempt counter = 0, state = ENTRY.
- Output timing:
  - Outputs are registered and update on the cycle after the triggering pulse.
  - unlocked and locked_out are decoded from the registered state.

Test Plan:
- Reset, then enter 1,2,3,4 (DEBOUNCE_CYCLES = 4) -> entered_code steps 1000, 1200, 1230; CHECK; unlocked = 1 one cycle later; attempt counter 0.
- Press down once from reset -> digit_nibble = F. Press up -> 0. Hold up for 100 cycles -> exactly one increment. A 2-cycle glitch -> no change.
- Enter 0000 three times (MAX_ATTEMPTS = 3, LOCKOUT_CYCLES = 20) -> three attempt_fail pulses, locked_out = 1 for 20 cycles with presses ignored, then ENTRY.
- Unlock, set_mode = 1, enter, program A,B,C,D, clear to relock -> 1234 fails; ABCD unlocks.
- Enter and up pulses in the same cycle -> only the commit occurs. Clear at digit_index 2 -> entered_code = 0, digit_index = 0.
- Assert rst_n low during PROGRAM after 2 digits -> all outputs at reset values; stored code is 1234 again.

Source files
------------

// File: rtl/vga_lock_code_entry.sv
// ---------------------------------------------------------------------------
// vga_lock_code_entry
//
// Button-driven passcode entry and lock controller. Four raw push-buttons
// are synchronised and debounced, then turned into single-cycle press pulses.
// The user edits one hex digit at a time; after the fourth digit is committed
// the entered code is compared against the stored passcode. Repeated failures
// lead to a timed lockout. While unlocked, the passcode can be reprogrammed.
//
// Ports
//   clk          : system clock, rising edge
//   rst_n        : synchronous active-low reset
//   btn_up       : raw button, increment current digit
//   btn_down     : raw button, decrement current digit
//   btn_enter    : raw button, commit current digit
//   btn_clear    : raw button, abort entry / relock
//   set_mode     : level switch, selects programming while unlocked
//   digit_nibble : value of the digit being edited (to the hex converter)
//   digit_index  : position being edited, 0 = most significant
//   entered_code : committed digits, digit k at [15-4k:12-4k]
//   unlocked     : high in UNLOCKED and PROGRAM
//   locked_out   : high in LOCKOUT
//   attempt_fail : one-cycle pulse on each failed check
//   fsm_state    : current state encoding (debug / display)
//
// Press pulses are single-cycle strobes; only the highest-priority one
// (clear > enter > up > down) acts in a given cycle. A press arriving in a
// state that does not use it is dropped, never queued.
// ---------------------------------------------------------------------------
module vga_lock_code_entry #(
   parameter int          DEBOUNCE_CYCLES = 250000,
   parameter int          MAX_ATTEMPTS    = 3,
   parameter int          LOCKOUT_CYCLES  = 50000000,
   parameter logic [15:0] DEFAULT_CODE    = 16'h1234
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_enter,
   input  logic        btn_clear,
   input  logic        set_mode,
   output logic [3:0]  digit_nibble,
   output logic [1:0]  digit_index,
   output logic [15:0] entered_code,
   output logic        unlocked,
   output logic        locked_out,
   output logic        attempt_fail,
   output logic [2:0]  fsm_state
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

   localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
   localparam logic [TW-1:0] LOCK_LD  = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [2:0]    MAX_FAIL = 3'(MAX_ATTEMPTS);

   typedef enum logic [2:0] {
      ST_ENTRY    = 3'd0,
      ST_CHECK    = 3'd1,
      ST_UNLOCKED = 3'd2,
      ST_PROGRAM  = 3'd3,
      ST_LOCKOUT  = 3'd4
   } state_t;

   // Button vector order: 0 up, 1 down, 2 enter, 3 clear
   logic [3:0]    raw_btn;
   logic [3:0]    sync_a;
   logic [3:0]    sync_b;
   logic [3:0]    db_level;
   logic [3:0]    db_level_q;
   logic [DW-1:0] db_cnt [4];
   logic [3:0]    press;

   assign raw_btn = {btn_clear, btn_enter, btn_down, btn_up};

   // Counter saturates at DB_MAX; the level rises on the count reaching
   // DB_MAX and drops on the first low synchronised sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_a     <= '0;
         sync_b     <= '0;
         db_level   <= '0;
         db_level_q <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         sync_a     <= raw_btn;
         sync_b     <= sync_a;
         db_level_q <= db_level;
         for (int i = 0; i < 4; i++) begin
            if (!sync_b[i]) begin
               db_cnt[i]   <= '0;
               db_level[i] <= 1'b0;
            end else if (db_cnt[i] != DB_MAX) begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
               if (db_cnt[i] == DB_MAX - DW'(1)) db_level[i] <= 1'b1;
            end
         end
      end
   end

   assign press = db_level & ~db_level_q;

   // Priority resolution: only one action per cycle
   logic act_clear, act_enter, act_up, act_down;
   assign act_clear = press[3];
   assign act_enter = press[2] & ~press[3];
   assign act_up    = press[0] & ~press[2] & ~press[3];
   assign act_down  = press[1] & ~press[0] & ~press[2] & ~press[3];

   state_t        state;
   logic [15:0]   stored_code;
   logic [2:0]    attempt_cnt;
   logic [TW-1:0] lock_timer;
   logic [15:0]   committed_code;

   // entered_code with the current nibble written into the active slot
   always_comb begin
      committed_code = entered_code;
      case (digit_index)
         2'd0:    committed_code[15:12] = digit_nibble;
         2'd1:    committed_code[11:8]  = digit_nibble;
         2'd2:    committed_code[7:4]   = digit_nibble;
         default: committed_code[3:0]   = digit_nibble;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_ENTRY;
         digit_nibble <= '0;
         digit_index  <= '0;
         entered_code <= '0;
         stored_code  <= DEFAULT_CODE;
         attempt_cnt  <= '0;
         lock_timer   <= '0;
         attempt_fail <= 1'b0;
      end else begin
         attempt_fail <= 1'b0;
         case (state)
            ST_ENTRY, ST_PROGRAM: begin
               if (act_clear) begin
                  digit_nibble <= '0;
                  digit_index  <= '0;
                  entered_code <= '0;
                  if (state == ST_PROGRAM) state <= ST_UNLOCKED;
               end else if (act_enter) begin
                  digit_nibble <= '0;
                  if (digit_index == 2'd3) begin
                     if (state == ST_PROGRAM) begin
                        stored_code  <= committed_code;
                        entered_code <= '0;
                        digit_index  <= '0;
                        state        <= ST_UNLOCKED;
                     end else begin
                        // Full code is held for the compare in CHECK
                        entered_code <= committed_code;
                        state        <= ST_CHECK;
                     end
                  end else begin
                     entered_code <= committed_code;
                     digit_index  <= digit_index + 2'd1;
                  end
               end else if (act_up) begin
                  digit_nibble <= digit_nibble + 4'd1;
               end else if (act_down) begin
                  digit_nibble <= digit_nibble - 4'd1;
               end
            end

            ST_CHECK: begin
               digit_nibble <= '0;
               digit_index  <= '0;
               entered_code <= '0;
               if (entered_code == stored_code) begin
                  attempt_cnt <= '0;
                  state       <= ST_UNLOCKED;
               end else begin
                  attempt_fail <= 1'b1;
                  attempt_cnt  <= attempt_cnt + 3'd1;
                  if (attempt_cnt + 3'd1 == MAX_FAIL) begin
                     lock_timer <= LOCK_LD;
                     state      <= ST_LOCKOUT;
                  end else begin
                     state <= ST_ENTRY;
                  end
               end
            end

            ST_UNLOCKED: begin
               if (act_clear) begin
                  state <= ST_ENTRY;
               end else if (act_enter && set_mode) begin
                  digit_nibble <= '0;
                  digit_index  <= '0;
                  entered_code <= '0;
                  state        <= ST_PROGRAM;
               end
            end

            ST_LOCKOUT: begin
               if (lock_timer == '0) begin
                  attempt_cnt <= '0;
                  state       <= ST_ENTRY;
               end else begin
                  lock_timer <= lock_timer - TW'(1);
               end
            end

            default: state <= ST_ENTRY;
         endcase
      end
   end

   assign fsm_state  = state;
   assign unlocked   = (state == ST_UNLOCKED) || (state == ST_PROGRAM);
   assign locked_out = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_vga_lock_code_entry.sv
// ---------------------------------------------------------------------------
// tb_vga_lock_code_entry
//
// Directed and randomized stimulus for the lock controller with small
// debounce/lockout parameters. A behavioural model (mode, digit array,
// stored code, failure count) tracks expected outputs after each press.
// ---------------------------------------------------------------------------
module tb_vga_lock_code_entry;

   localparam int DC = 4;
   localparam int MA = 3;
   localparam int LC = 20;

   localparam logic [3:0] B_UP    = 4'b0001;
   localparam logic [3:0] B_DOWN  = 4'b0010;
   localparam logic [3:0] B_ENTER = 4'b0100;
   localparam logic [3:0] B_CLEAR = 4'b1000;

   // Model modes use the state numbering of the block's fsm_state output
   localparam int M_ENTRY = 0, M_UNLOCKED = 2, M_PROGRAM = 3, M_LOCKOUT = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        btn_up = 0, btn_down = 0, btn_enter = 0, btn_clear = 0;
   logic        set_mode = 0;
   logic [3:0]  digit_nibble;
   logic [1:0]  digit_index;
   logic [15:0] entered_code;
   logic        unlocked, locked_out, attempt_fail;
   logic [2:0]  fsm_state;

   vga_lock_code_entry #(
      .DEBOUNCE_CYCLES(DC),
      .MAX_ATTEMPTS   (MA),
      .LOCKOUT_CYCLES (LC),
      .DEFAULT_CODE   (16'h1234)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .btn_enter   (btn_enter),
      .btn_clear   (btn_clear),
      .set_mode    (set_mode),
      .digit_nibble(digit_nibble),
      .digit_index (digit_index),
      .entered_code(entered_code),
      .unlocked    (unlocked),
      .locked_out  (locked_out),
      .attempt_fail(attempt_fail),
      .fsm_state   (fsm_state)
   );

   // ---------------- monitors ----------------
   int fail_seen  = 0;
   int lock_seen  = 0;
   always @(negedge clk) begin
      if (attempt_fail === 1'b1) fail_seen++;
      if (locked_out === 1'b1) lock_seen++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard / model ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   int          m_mode, m_nib, m_idx, m_fails, m_pulses;
   int          m_digits [4];
   logic [15:0] m_stored;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] m_pack();
      logic [15:0] c = '0;
      for (int k = 0; k < 4; k++) c = c | (16'(m_digits[k]) << (12 - 4 * k));
      return c;
   endfunction

   task automatic m_clear_entry();
      m_nib = 0;
      m_idx = 0;
      for (int k = 0; k < 4; k++) m_digits[k] = 0;
   endtask

   task automatic m_reset();
      m_clear_entry();
      m_mode   = M_ENTRY;
      m_fails  = 0;
      m_stored = 16'h1234;
   endtask

   task automatic m_press(input logic [3:0] mask);
      int act;
      logic [15:0] full;
      if (m_mode == M_LOCKOUT) return;
      if (mask[3]) act = 3;
      else if (mask[2]) act = 2;
      else if (mask[0]) act = 0;
      else if (mask[1]) act = 1;
      else return;
      if (m_mode == M_ENTRY || m_mode == M_PROGRAM) begin
         if (act == 3) begin
            m_clear_entry();
            if (m_mode == M_PROGRAM) m_mode = M_UNLOCKED;
         end else if (act == 0) begin
            m_nib = (m_nib + 1) % 16;
         end else if (act == 1) begin
            m_nib = (m_nib + 15) % 16;
         end else begin
            m_digits[m_idx] = m_nib;
            m_nib = 0;
            if (m_idx == 3) begin
               full = m_pack();
               m_clear_entry();
               if (m_mode == M_PROGRAM) begin
                  m_stored = full;
                  m_mode   = M_UNLOCKED;
               end else if (full == m_stored) begin
                  m_mode  = M_UNLOCKED;
                  m_fails = 0;
               end else begin
                  m_fails++;
                  m_pulses++;
                  m_mode = (m_fails == MA) ? M_LOCKOUT : M_ENTRY;
               end
            end else begin
               m_idx++;
            end
         end
      end else if (m_mode == M_UNLOCKED) begin
         if (act == 3) m_mode = M_ENTRY;
         else if (act == 2 && set_mode) m_mode = M_PROGRAM;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ":nibble"}, 32'(digit_nibble), 32'(m_nib));
      check({tag, ":index"},  32'(digit_index),  32'(m_idx));
      check({tag, ":code"},   32'(entered_code), 32'(m_pack()));
      check({tag, ":unlocked"}, 32'(unlocked),
            32'(m_mode == M_UNLOCKED || m_mode == M_PROGRAM));
      check({tag, ":locked_out"}, 32'(locked_out), 32'(m_mode == M_LOCKOUT));
      check({tag, ":state"},  32'(fsm_state),    32'(m_mode));
      check({tag, ":fail_pulses"}, 32'(fail_seen), 32'(m_pulses));
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_btns(input logic [3:0] mask);
      btn_up    = mask[0];
      btn_down  = mask[1];
      btn_enter = mask[2];
      btn_clear = mask[3];
   endtask

   task automatic press(input logic [3:0] mask, input string tag);
      @(negedge clk);
      drive_btns(mask);
      repeat (DC + 6) @(negedge clk);
      drive_btns(4'b0000);
      repeat (8) @(negedge clk);
      m_press(mask);
      check_all(tag);
   endtask

   task automatic enter_digit(input int v, input string tag);
      if (v <= 8) for (int k = 0; k < v; k++) press(B_UP, tag);
      else for (int k = 0; k < 16 - v; k++) press(B_DOWN, tag);
      press(B_ENTER, tag);
   endtask

   task automatic enter_code(input logic [15:0] c, input string tag);
      for (int k = 0; k < 4; k++) enter_digit(int'(c[15 - 4 * k -: 4]), tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      drive_btns(4'b0000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      @(negedge clk);
      check_all(tag);
      check({tag, ":attempt_fail"}, 32'(attempt_fail), 32'd0);
   endtask

   task automatic wait_lockout_end(input string tag);
      for (int k = 0; k < 200 && locked_out === 1'b1; k++) @(negedge clk);
      check({tag, ":lockout_ended"}, 32'(locked_out), 32'd0);
      m_mode  = M_ENTRY;
      m_fails = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lock_before;
      logic [3:0] mask;
      int r;

      m_pulses = 0;
      m_reset();
      repeat (2) @(negedge clk);
      do_reset("reset");

      // Unlock with default code, checking partial codes
      enter_digit(1, "d1");
      check("code_1000", 32'(entered_code), 32'h1000);
      enter_digit(2, "d2");
      check("code_1200", 32'(entered_code), 32'h1200);
      enter_digit(3, "d3");
      check("code_1230", 32'(entered_code), 32'h1230);
      enter_digit(4, "d4");
      check("unlock_default", 32'(unlocked), 32'd1);
      press(B_CLEAR, "relock");

      // Wrap-around, held button, glitch
      press(B_DOWN, "down_wrap");
      check("nibble_F", 32'(digit_nibble), 32'hF);
      press(B_UP, "up_wrap");
      @(negedge clk);
      btn_up = 1'b1;
      repeat (100) @(negedge clk);
      btn_up = 1'b0;
      repeat (8) @(negedge clk);
      m_press(B_UP);
      check_all("hold_up");
      check("hold_one_step", 32'(digit_nibble), 32'd1);
      btn_up = 1'b1;
      repeat (2) @(negedge clk);
      btn_up = 1'b0;
      repeat (10) @(negedge clk);
      check_all("glitch");
      press(B_CLEAR, "clr");

      // Three failures, lockout ignoring presses
      enter_code(16'h0000, "bad1");
      enter_code(16'h0000, "bad2");
      for (int k = 0; k < 3; k++) press(B_ENTER, "bad3");
      lock_before = lock_seen;
      @(negedge clk);
      btn_enter = 1'b1;
      for (int k = 0; k < 40 && locked_out !== 1'b1; k++) @(negedge clk);
      check("lockout_entered", 32'(locked_out), 32'd1);
      m_press(B_ENTER);
      btn_enter = 1'b0;
      btn_up    = 1'b1;
      repeat (DC + 6) @(negedge clk);
      btn_up = 1'b0;
      wait_lockout_end("lock");
      check("lockout_len", 32'(lock_seen - lock_before), 32'(LC));
      check_all("after_lock");

      // Reprogram to ABCD
      enter_code(16'h1234, "unl");
      set_mode = 1'b1;
      press(B_ENTER, "to_prog");
      check("prog_state", 32'(fsm_state), 32'd3);
      enter_code(16'hABCD, "prog");
      set_mode = 1'b0;
      check("prog_done", 32'(fsm_state), 32'd2);
      press(B_CLEAR, "relock2");
      enter_code(16'h1234, "old_code");
      check("old_code_rejected", 32'(unlocked), 32'd0);
      enter_code(16'hABCD, "new_code");
      check("new_code_accepted", 32'(unlocked), 32'd1);
      press(B_CLEAR, "relock3");

      // Enter beats up in the same cycle; clear mid-entry
      press(B_UP, "pre");
      press(B_ENTER | B_UP, "enter_up");
      check("enter_up_code", 32'(entered_code), 32'h1000);
      check("enter_up_nib", 32'(digit_nibble), 32'd0);
      enter_digit(5, "d5");
      press(B_UP, "pre_clr");
      press(B_CLEAR, "clr_idx2");
      check("clr_code", 32'(entered_code), 32'd0);
      check("clr_index", 32'(digit_index), 32'd0);

      // Reset during programming restores default code
      enter_code(16'hABCD, "unl2");
      set_mode = 1'b1;
      press(B_ENTER, "to_prog2");
      enter_digit(7, "p7");
      enter_digit(8, "p8");
      set_mode = 1'b0;
      do_reset("reset_prog");
      enter_code(16'h1234, "default_back");
      check("default_restored", 32'(unlocked), 32'd1);

      // Randomized presses against the model
      for (int it = 0; it < 40; it++) begin
         set_mode = 1'($urandom_range(0, 1));
         if (it % 10 == 9) begin
            for (int k = 0; k < 3 && m_mode != M_ENTRY; k++) press(B_CLEAR, "rnd_norm");
            press(B_CLEAR, "rnd_norm");
            enter_code(m_stored, "rnd_code");
         end else begin
            r = $urandom_range(0, 19);
            if (r <= 6) mask = B_UP;
            else if (r <= 10) mask = B_DOWN;
            else if (r <= 15) mask = B_ENTER;
            else if (r == 16) mask = B_CLEAR;
            else if (r == 17) mask = B_ENTER | B_UP;
            else if (r == 18) mask = B_CLEAR | B_ENTER;
            else mask = B_UP | B_DOWN;
            press(mask, "rnd");
         end
         if (m_mode == M_LOCKOUT) begin
            wait_lockout_end("rnd_lock");
            check_all("rnd_after_lock");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
